data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the MEM stage of the ARM pipeline: accepts the load/store requests driven by the execute stage (address from `alu_result`, store data from `val_rm`, `mem_R_en`/`mem_W_en`) and services them from an internal word array behind a configurable wait-state FSM. `ready` stalls the pipeline while an access is in flight. Sits between the EX/MEM register and the MEM/WB register.

## Interface
- `DEPTH`, 64: number of 32-bit words in the array; power of two, ≥ 2.
- `BASE_ADDR`, 1024: byte address mapped to word 0.
- `WAIT_CYCLES`, 5: wait states per access; range 0–15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_R_en` in 1: load request; held until `ready` is seen high.
- `mem_W_en` in 1: store request; held until `ready` is seen high.
- `alu_result` in 32: byte address of the access.
- `val_rm` in 32: store data.
- `read_data` out 32: load result; registered.
- `ready` out 1: high when no access is pending or the access is completing this cycle.
- `err` out 1: completing access was out of range or misaligned; registered.

## Operation
- Word index = (`alu_result` − `BASE_ADDR`) >> 2, computed in 32-bit unsigned arithmetic with wrap.
- Out of range means index ≥ `DEPTH`, which includes addresses below `BASE_ADDR` through wrap. Out-of-range reads return 0, writes are dropped, and `err`=1 in DONE.
- Request = `mem_R_en` | `mem_W_en`. If both are high, the access is a store and `read_data` is 0.
- FSM states:
  - IDLE:
    - With no request, `ready`=1 and the state holds.
    - With a request, `ready`=0 combinationally. The next state is WAIT with counter = `WAIT_CYCLES`−1, or DONE if `WAIT_CYCLES`=0.
  - WAIT: `ready`=0 and the counter decrements. At counter = 0 the next state is DONE.
  - DONE:
    - `ready`=1.
    - `read_data` and `err` hold the result, which was registered on the edge into DONE.
    - A store commits to the array on that same edge.
    - The next state is always IDLE, because the pipeline advances at the end of DONE and the request is then stale.
- Request inputs are sampled on the edge into DONE. Changing them before `ready` is protocol misuse and the result is undefined.
- `read_data`/`err` hold until the next DONE entry.
- The array is not cleared by reset.

## Timing
- Reset values: state IDLE, counter 0, `read_data` 0, `err` 0. While a request is present after reset, `ready` follows IDLE rules.
- Reset mid-access: the FSM returns to IDLE immediately and the pending store is discarded. After release, a still-asserted request restarts the full access.
- A request first seen in cycle n completes in DONE at cycle n+`WAIT_CYCLES`+1. `ready` is low for `WAIT_CYCLES`+1 cycles.
- `WAIT_CYCLES`=0: IDLE then DONE, one stall cycle.
- Back-to-back accesses: at least one IDLE cycle separates two DONEs, so the minimum period is `WAIT_CYCLES`+2 cycles.
- Store-then-load to the same address: the load sees the stored value, because the store committed on the edge into the earlier DONE.

## Configuration
- `DMEM_ALIGN_CHECK_EN`
- Defined:
  - `alu_result`[1:0] ≠ 0 sets `err`=1 in DONE.
  - A misaligned store is dropped.
  - A misaligned load returns 0.
  - The timing is unchanged.
- Not defined: `alu_result`[1:0] are ignored, and misalignment never sets `err`.

## Test plan
- Reset with `rst`=0, then release; no request → `ready`=1, `read_data`=0, `err`=0, FSM in IDLE.
- `WAIT_CYCLES`=5: store 0xDEADBEEF to 1028, then load 1028 → each access stalls 6 cycles, and the load returns 0xDEADBEEF in its DONE.
- `WAIT_CYCLES`=0: load from 1024 after storing 0x12345678 → one stall cycle, `read_data`=0x12345678.
- Load at 1020 and at `BASE_ADDR`+4·`DEPTH` → `read_data`=0, `err`=1. A store to 1020 leaves the array unchanged.
- Assert `rst`=0 in WAIT during a store of 0xAAAA5555 to 1032 → FSM returns to IDLE with `ready`=1. A subsequent load of 1032 returns the prior contents.
- With `DMEM_ALIGN_CHECK_EN`, store to 1026 → `err`=1 and no write. Without the macro → the word at 1024 is written and `err`=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Purpose: MEM-stage data memory; word array at BASE_ADDR served through a wait-state FSM (IDLE/WAIT/DONE).
// Latency: request seen in cycle n completes in DONE at n+WAIT_CYCLES+1; read_data/err registered on entry to DONE.
// Backpressure: ready low while an access is in flight; optional DMEM_ALIGN_CHECK_EN flags/drops misaligned accesses.
module data_mem_responder #(
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_R_en,
  input  logic        mem_W_en,
  input  logic [31:0] alu_result,
  input  logic [31:0] val_rm,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [31:0] mem [DEPTH];

  logic        req;
  logic        enter_done;
  logic [31:0] offset;
  logic [29:0] word_idx;
  logic [AW-1:0] widx;
  logic        in_range;
  logic        misaligned;
  logic        access_ok;
  logic [31:0] load_val;
  logic        unused_bits;

  assign req = mem_R_en | mem_W_en;

  // Word index is taken modulo 2^32, so addresses below the base wrap to huge indices and land out of range.
  assign offset   = alu_result - BASE_ADDR;
  assign word_idx = offset[31:2];
  assign widx     = word_idx[AW-1:0];
  assign in_range = (word_idx < 30'(DEPTH));

  // The byte-lane bits of the offset only matter through alu_result when alignment checking is built in.
  assign unused_bits = ^offset[1:0];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (alu_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign access_ok  = in_range & ~misaligned;
  assign enter_done = (state_nxt == S_DONE);

  // Load result: stores (including read+write) return zero, as do rejected accesses.
  always_comb begin
    load_val = 32'd0;
    if (!mem_W_en && access_ok) begin
      load_val = mem[widx];
    end
  end

  // Next-state and ready: IDLE stalls combinationally on a request, DONE always releases and returns to IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    case (state)
      S_IDLE: begin
        ready = ~req;
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DONE: begin
        ready     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus result capture and store commit on the edge into DONE; the array itself is never reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      read_data <= 32'd0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (enter_done) begin
        read_data <= load_val;
        err       <= ~access_ok;
        if (mem_W_en && access_ok) begin
          mem[widx] <= val_rm;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two configurations (5 wait states / 64 words, 0 wait states / 8 words).
// Each configuration has a transaction-level memory model, a per-cycle output compare and directed + random accesses.
// Honours DMEM_ALIGN_CHECK_EN in its expectations when the macro is defined.
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int          WC    = (g == 0) ? 5 : 0;
    localparam int          DP    = (g == 0) ? 64 : 8;
    localparam logic [31:0] PAT   = (g == 0) ? 32'hDEADBEEF : 32'h12345678;
    localparam logic [31:0] PADDR = (g == 0) ? 32'd1028 : 32'd1024;

    logic        rst;
    logic        mem_R_en;
    logic        mem_W_en;
    logic [31:0] alu_result;
    logic [31:0] val_rm;
    logic [31:0] read_data;
    logic        ready;
    logic        err;

    logic [31:0] mm [DP];
    logic        exp_ready;
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          chk_on = 1'b0;
    bit          done   = 1'b0;

    data_mem_responder #(
      .DEPTH      (DP),
      .BASE_ADDR  (BASE),
      .WAIT_CYCLES(WC)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_R_en  (mem_R_en),
      .mem_W_en  (mem_W_en),
      .alu_result(alu_result),
      .val_rm    (val_rm),
      .read_data (read_data),
      .ready     (ready),
      .err       (err)
    );

    // Outputs are compared against the model every cycle, mid-cycle.
    always @(negedge clk) begin
      if (chk_on) begin
        chk($sformatf("c%0d ready", g), 32'(ready), 32'(exp_ready));
        chk($sformatf("c%0d read_data", g), read_data, exp_rd);
        chk($sformatf("c%0d err", g), 32'(err), 32'(exp_err));
      end
    end

    // Result of one access from the address-map rules.
    function automatic void predict(input bit w, input logic [31:0] a,
                                    output logic [31:0] erd, output logic eerr,
                                    output bit ok, output int idx);
      logic [31:0] off;
      bit          mis;
      off = a - BASE;
      idx = int'(off >> 2);
      mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      mis = ((a % 4) != 0);
`endif
      ok   = ((off >> 2) < 32'(DP)) && !mis;
      eerr = !ok;
      erd  = 32'd0;
      if (ok && !w) erd = mm[idx];
    endfunction

    // One access: hold the request until the DONE cycle, then drop it in the following IDLE cycle.
    task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] got_rd, output logic got_err);
      logic [31:0] erd;
      logic        eerr;
      bit          ok;
      int          idx;
      int          stalls;
      predict(w, a, erd, eerr, ok, idx);
      stalls     = 0;
      mem_R_en   = r;
      mem_W_en   = w;
      alu_result = a;
      val_rm     = d;
      exp_ready  = 1'b0;
      for (int k = 0; k <= WC; k++) begin
        @(negedge clk);
        if (!ready) stalls++;
        @(posedge clk); #1;
      end
      exp_ready = 1'b1;
      exp_rd    = erd;
      exp_err   = eerr;
      if (ok && w) mm[idx] = d;
      @(negedge clk);
      got_rd  = read_data;
      got_err = err;
      if (!ready) stalls++;
      chk($sformatf("c%0d stall_cycles", g), 32'(stalls), 32'(WC + 1));
      @(posedge clk); #1;
      mem_R_en = 1'b0;
      mem_W_en = 1'b0;
    endtask

    initial begin
      logic [31:0] rd;
      logic [31:0] prior;
      logic [31:0] a;
      logic        e;
      int          kind;
      bit          r;
      bit          w;

      rst        = 1'b0;
      mem_R_en   = 1'b0;
      mem_W_en   = 1'b0;
      alu_result = 32'd0;
      val_rm     = 32'd0;
      exp_ready  = 1'b1;
      exp_rd     = 32'd0;
      exp_err    = 1'b0;
      chk_on     = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk($sformatf("c%0d reset ready", g), 32'(ready), 32'd1);
      chk($sformatf("c%0d reset read_data", g), read_data, 32'd0);
      chk($sformatf("c%0d reset err", g), 32'(err), 32'd0);
      @(posedge clk); #1;

      // The array powers up unknown, so give every word a known value first.
      for (int i = 0; i < DP; i++) begin
        access(1'b0, 1'b1, BASE + 32'(4 * i), $urandom, rd, e);
      end

      // Store then load the same word.
      access(1'b0, 1'b1, PADDR, PAT, rd, e);
      chk($sformatf("c%0d store err", g), 32'(e), 32'd0);
      chk($sformatf("c%0d store read_data", g), rd, 32'd0);
      access(1'b1, 1'b0, PADDR, 32'd0, rd, e);
      chk($sformatf("c%0d load pattern", g), rd, PAT);
      chk($sformatf("c%0d load err", g), 32'(e), 32'd0);

      // Out of range on both sides of the window.
      access(1'b1, 1'b0, BASE - 32'd4, 32'd0, rd, e);
      chk($sformatf("c%0d below-base read_data", g), rd, 32'd0);
      chk($sformatf("c%0d below-base err", g), 32'(e), 32'd1);
      access(1'b1, 1'b0, BASE + 32'(4 * DP), 32'd0, rd, e);
      chk($sformatf("c%0d above-top read_data", g), rd, 32'd0);
      chk($sformatf("c%0d above-top err", g), 32'(e), 32'd1);
      access(1'b0, 1'b1, BASE - 32'd4, 32'hCAFEF00D, rd, e);
      chk($sformatf("c%0d oor store err", g), 32'(e), 32'd1);
      access(1'b1, 1'b0, BASE + 32'(4 * (DP - 1)), 32'd0, rd, e);
      chk($sformatf("c%0d last word", g), rd, mm[DP-1]);

      // Misaligned store to base+2.
      prior = mm[0];
      access(1'b0, 1'b1, BASE + 32'd2, 32'h0BADF00D, rd, e);
`ifdef DMEM_ALIGN_CHECK_EN
      chk($sformatf("c%0d misaligned err", g), 32'(e), 32'd1);
      access(1'b1, 1'b0, BASE, 32'd0, rd, e);
      chk($sformatf("c%0d misaligned dropped", g), rd, prior);
`else
      chk($sformatf("c%0d misaligned err", g), 32'(e), 32'd0);
      access(1'b1, 1'b0, BASE, 32'd0, rd, e);
      chk($sformatf("c%0d misaligned written", g), rd, 32'h0BADF00D);
      chk($sformatf("c%0d misaligned prior differs", g), 32'(rd != prior || prior == 32'h0BADF00D), 32'd1);
`endif

      // Reset while a store is in flight: the store must be discarded.
      prior      = mm[2];
      mem_W_en   = 1'b1;
      alu_result = BASE + 32'd8;
      val_rm     = 32'hAAAA5555;
      exp_ready  = 1'b0;
      repeat ((WC >= 2) ? 2 : 0) begin
        @(posedge clk); #1;
      end
      @(negedge clk); #1;
      rst       = 1'b0;
      mem_W_en  = 1'b0;
      exp_ready = 1'b1;
      exp_rd    = 32'd0;
      exp_err   = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk($sformatf("c%0d mid-reset ready", g), 32'(ready), 32'd1);
      @(posedge clk); #1;
      access(1'b1, 1'b0, BASE + 32'd8, 32'd0, rd, e);
      chk($sformatf("c%0d after mid-reset load", g), rd, prior);

      // Randomized accesses with 0..2 idle cycles between them.
      for (int n = 0; n < 120; n++) begin
        kind = int'($urandom_range(0, 9));
        if (kind <= 6)      a = BASE + 32'(4 * $urandom_range(0, DP - 1));
        else if (kind == 7) a = BASE + 32'(4 * $urandom_range(0, DP - 1)) + 32'($urandom_range(1, 3));
        else if (kind == 8) a = BASE - 32'(4 * $urandom_range(1, 4));
        else                a = BASE + 32'(4 * DP) + 32'(4 * $urandom_range(0, 1000));
        case ($urandom_range(0, 3))
          0, 3:    begin r = 1'b1; w = 1'b0; end
          1:       begin r = 1'b0; w = 1'b1; end
          default: begin r = 1'b1; w = 1'b1; end
        endcase
        access(r, w, a, $urandom, rd, e);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(cfg[0].done && cfg[1].done) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (!(cfg[0].done && cfg[1].done)) begin
      miscompares++;
      $display("FAIL timeout: sequences not complete after %0d cycles", t);
    end
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
